// File: rtl/prog_loader.sv
// Program loader: copies a stream of up to 32 bytes into main store through the MAR/bus path,
// holding the core in reset meanwhile. Optional readback check is enabled by LOADER_VERIFY_EN.
module prog_loader (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [5:0] i_len,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic [7:0] o_bus_out,
    output logic       o_e_load,
    output logic       o_we_mar,
    output logic       o_write,
    output logic       o_read,
    input  logic [7:0] i_ms_in,
    output logic       o_core_hold,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
`ifdef LOADER_VERIFY_EN
        S_VRD,
        S_VCHK,
`endif
        S_FIN
    } state_t;

    state_t      r_state;
    logic [4:0]  r_addr;
    logic [5:0]  r_count;
    logic [5:0]  r_len;
    logic [7:0]  r_byte;
    logic        r_in_ready;
    logic [7:0]  r_bus_out;
    logic        r_e_load;
    logic        r_we_mar;
    logic        r_write;
    logic        r_core_hold;
    logic        r_done;
    logic        w_last;

`ifdef LOADER_VERIFY_EN
    logic        r_read;
    logic        r_err;
`else
    logic        w_ms_in_unused;
    assign w_ms_in_unused = ^i_ms_in;
`endif

    // True when the byte currently being finished is the last one of the session.
    assign w_last = ((r_count + 6'd1) == r_len);

    // Outputs are registered: each transition loads the strobes that belong to the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 5'd0;
            r_count     <= 6'd0;
            r_len       <= 6'd0;
            r_byte      <= 8'd0;
            r_in_ready  <= 1'b0;
            r_bus_out   <= 8'd0;
            r_e_load    <= 1'b0;
            r_we_mar    <= 1'b0;
            r_write     <= 1'b0;
            r_core_hold <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_read      <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_in_ready  <= 1'b0;
            r_bus_out   <= 8'd0;
            r_e_load    <= 1'b0;
            r_we_mar    <= 1'b0;
            r_write     <= 1'b0;
            r_core_hold <= 1'b1;
            r_done      <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_read      <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len      <= (i_len == 6'd0) ? 6'd32 : i_len;
                        r_addr     <= 5'd0;
                        r_count    <= 6'd0;
`ifdef LOADER_VERIFY_EN
                        r_err      <= 1'b0;
`endif
                        r_in_ready <= 1'b1;
                        r_state    <= S_WAIT;
                    end else begin
                        r_core_hold <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_in_valid && r_in_ready) begin
                        r_byte    <= i_in_data;
                        r_e_load  <= 1'b1;
                        r_we_mar  <= 1'b1;
                        r_bus_out <= {3'b000, r_addr};
                        r_state   <= S_ADDR;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_ADDR: begin
                    r_e_load  <= 1'b1;
                    r_write   <= 1'b1;
                    r_bus_out <= r_byte;
                    r_state   <= S_DATA;
                end
`ifdef LOADER_VERIFY_EN
                S_DATA: begin
                    r_read  <= 1'b1;
                    r_state <= S_VRD;
                end
                S_VRD: begin
                    r_state <= S_VCHK;
                end
                S_VCHK: begin
                    if (i_ms_in != r_byte) begin
                        r_err <= 1'b1;
                    end
                    r_addr  <= r_addr + 5'd1;
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
`else
                S_DATA: begin
                    r_addr  <= r_addr + 5'd1;
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
`endif
                S_FIN: begin
                    r_core_hold <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_core_hold <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_bus_out   = r_bus_out;
    assign o_e_load    = r_e_load;
    assign o_we_mar    = r_we_mar;
    assign o_write     = r_write;
    assign o_core_hold = r_core_hold;
    assign o_done      = r_done;
`ifdef LOADER_VERIFY_EN
    assign o_read      = r_read;
    assign o_err       = r_err;
`else
    assign o_read      = 1'b0;
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected (address, byte) pairs are queued as bytes are offered
// and popped when the loader strobes the store; readback path is exercised when LOADER_VERIFY_EN is defined.
module tb_prog_loader;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wrExp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  len;
    logic        inValid;
    logic [7:0]  inData;
    logic [7:0]  msIn;
    logic        inReady;
    logic [7:0]  busOut;
    logic        eLoad;
    logic        weMar;
    logic        writeStb;
    logic        readStb;
    logic        coreHold;
    logic        done;
    logic        err;
    logic [15:0] outVec;

    wrExp_t      expQ[$];
    int          checkCount = 0;
    int          failCount = 0;
    logic [4:0]  expAddr = 5'd0;
    logic [4:0]  lastMar = 5'd0;
    logic [7:0]  memModel [32];
    logic        corruptRead = 1'b0;

    prog_loader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_len       (len),
        .i_in_valid  (inValid),
        .i_in_data   (inData),
        .o_in_ready  (inReady),
        .o_bus_out   (busOut),
        .o_e_load    (eLoad),
        .o_we_mar    (weMar),
        .o_write     (writeStb),
        .o_read      (readStb),
        .i_ms_in     (msIn),
        .o_core_hold (coreHold),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    assign outVec = {inReady, eLoad, weMar, writeStb, readStb, coreHold, done, err, busOut};

    // Main store stand-in: returns what was written at the MAR address unless told to corrupt it.
    assign msIn = corruptRead ? 8'hFF : memModel[lastMar];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Bus-side monitor: checks strobe rules every cycle and retires scoreboard entries on store writes.
    always @(negedge clk) begin
        wrExp_t e;
        int nStrobe;
        nStrobe = int'(weMar) + int'(writeStb) + int'(readStb);
        if (!eLoad) checkOutput("busIdleZero", {24'd0, busOut}, 32'd0);
        if (eLoad) checkOutput("eLoadOnlyAddrData", {31'd0, weMar | writeStb}, 32'd1);
        if (nStrobe != 0) checkOutput("strobeExclusive", nStrobe, 32'd1);
        if (weMar) lastMar = busOut[4:0];
        if (writeStb) begin
            memModel[lastMar] = busOut;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("writeAddr", {27'd0, lastMar}, {27'd0, e.addr});
                checkOutput("writeData", {24'd0, busOut}, {24'd0, e.data});
            end
        end
    end

    task automatic startSession(input logic [5:0] l);
        start   = 1'b1;
        len     = l;
        expAddr = 5'd0;
        @(negedge clk);
        start = 1'b0;
        len   = 6'd0;
        checkOutput("sessionEntry", {30'd0, coreHold, inReady}, 32'd3);
        checkOutput("errClearedOnStart", {31'd0, err}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        wrExp_t e;
        int n;
        n       = 0;
        inValid = 1'b1;
        inData  = data;
        e.addr  = expAddr;
        e.data  = data;
        expQ.push_back(e);
        expAddr = expAddr + 5'd1;
        while (!inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyWithinBound", {31'd0, inReady}, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
        inData  = 8'h00;
    endtask

    task automatic waitDone(input string tag, input logic expErr);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "DoneSeen"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "HoldInFin"}, {31'd0, coreHold}, 32'd1);
        checkOutput({tag, "AllWritten"}, expQ.size(), 32'd0);
        checkOutput({tag, "ErrAtDone"}, {31'd0, err}, {31'd0, expErr});
        @(negedge clk);
        checkOutput({tag, "DoneOnePulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "HoldFalls"}, {31'd0, coreHold}, 32'd0);
        checkOutput({tag, "ErrAfterDone"}, {31'd0, err}, {31'd0, expErr});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) memModel[i] = 8'h00;
        rst     = 1'b1;
        start   = 1'b0;
        len     = 6'd0;
        inValid = 1'b0;
        inData  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", {16'd0, outVec}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleOutputs", {16'd0, outVec}, 32'd0);

        // Basic three-byte load.
        startSession(6'd3);
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        waitDone("basic", 1'b0);

        // Source stalls for ten cycles while the loader waits.
        startSession(6'd2);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stallReady", {31'd0, inReady}, 32'd1);
            checkOutput("stallNoStrobe", {28'd0, eLoad, weMar, writeStb, readStb}, 32'd0);
            @(negedge clk);
        end
        applyStimulus(8'h5E);
        applyStimulus(8'hE5);
        waitDone("stall", 1'b0);

        // len=0 means a full 32-byte image.
        startSession(6'd0);
        for (int i = 0; i < 32; i++) applyStimulus(8'(i));
        waitDone("full32", 1'b0);

        // A start pulse in DATA must not disturb the running session.
        startSession(6'd2);
        applyStimulus(8'h3C);
        @(negedge clk);
        checkOutput("inDataState", {31'd0, writeStb}, 32'd1);
        start = 1'b1;
        len   = 6'd5;
        @(negedge clk);
        start = 1'b0;
        len   = 6'd0;
        applyStimulus(8'h4D);
        waitDone("ignoredStart", 1'b0);
        checkOutput("staysIdle", {31'd0, inReady}, 32'd0);

        // Reset during DATA of the second byte aborts the session.
        startSession(6'd4);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        @(negedge clk);
        checkOutput("rstInDataState", {31'd0, writeStb}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midResetOutputs", {16'd0, outVec}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("afterAbortOutputs", {16'd0, outVec}, 32'd0);
        checkOutput("abortQueueEmpty", expQ.size(), 32'd0);
        startSession(6'd1);
        applyStimulus(8'h77);
        waitDone("afterAbort", 1'b0);

`ifdef LOADER_VERIFY_EN
        // Clean readback leaves err low; corrupted readback sets it until the next start.
        startSession(6'd2);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        waitDone("verifyClean", 1'b0);
        corruptRead = 1'b1;
        startSession(6'd1);
        applyStimulus(8'h5A);
        waitDone("verifyBad", 1'b1);
        corruptRead = 1'b0;
        startSession(6'd1);
        applyStimulus(8'h66);
        waitDone("verifyRecover", 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 start  input  1  shall request a load session; sampled only in IDLE.
REQ-003 len  input  6  shall give the byte count; 1..32 valid, 0 treated as 32; captured on accepted start.
REQ-004 in_valid  input  1  shall indicate that the source holds a byte on in_data.
REQ-005 in_data  input  8  shall carry the program byte.
REQ-006 in_ready  output  1  shall indicate that the loader accepts a byte this cycle.
REQ-007 bus_out  output  8  shall carry the value the loader drives onto the main bus; 0 when e_load=0.
REQ-008 e_load  output  1  shall be the loader's bus drive enable, ORed into the main bus mux.
REQ-009 we_mar  output  1  shall be the MAR write enable.
REQ-010 write  output  1  shall be the main store write strobe.
REQ-011 read  output  1  shall be the main store read strobe; constant 0 without LOADER_VERIFY_EN.
REQ-012 ms_in  input  8  shall carry the main store read data; ignored without LOADER_VERIFY_EN.
REQ-013 core_hold  output  1  shall hold the core control unit in reset while a session is active.
REQ-014 done  output  1  shall pulse for one cycle when a session completes.
REQ-015 err  output  1  shall be a sticky readback-mismatch flag; constant 0 without LOADER_VERIFY_EN.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT, ADDR, DATA, VRD, VCHK and FIN, with VRD and VCHK present only under LOADER_VERIFY_EN.
REQ-017 In IDLE, start=1 SHALL capture len, clear the 5-bit address counter and err, and go to WAIT next cycle.
REQ-018 core_hold SHALL be 1 in every state except IDLE.
REQ-019 In WAIT, in_ready SHALL be 1; on in_valid & in_ready the FSM SHALL latch in_data and go to ADDR; otherwise it stays in WAIT indefinitely.
REQ-020 in_ready SHALL be 0 in all states other than WAIT; bytes offered then SHALL NOT be consumed.
REQ-021 In ADDR, the loader SHALL assert e_load=1 and we_mar=1 with bus_out={3'b000, addr}, then go to DATA.
REQ-022 In DATA, the loader SHALL assert e_load=1 and write=1 with bus_out equal to the latched byte, then go to VRD (verify) or to the next-byte decision.
REQ-023 Next-byte decision: the address counter increments by one; if the number of bytes written equals len the FSM SHALL go to FIN, else to WAIT.
REQ-024 With len=32, the address SHALL reach 31 on the last byte; the counter wrap to 0 after the session is don't-care.
REQ-025 Minimum throughput without verify SHALL be one byte per 3 cycles (WAIT, ADDR, DATA).
REQ-026 FIN SHALL assert done=1 for one cycle, deassert core_hold at the next state, and return to IDLE.
REQ-027 start asserted outside IDLE SHALL be ignored.
REQ-028 we_mar, write and read SHALL be mutually exclusive in every cycle, and e_load SHALL be 1 only in ADDR and DATA.

Reset
REQ-029 With rst=1 at a clock edge, the loader SHALL enter IDLE and clear the address counter, byte count, latched byte and err.
REQ-030 During and after reset, all outputs SHALL be 0, including core_hold.
REQ-031 Reset mid-session SHALL abort the session, with no further bus, MAR or store strobes.

Configuration
REQ-032 With LOADER_VERIFY_EN defined, DATA SHALL go to VRD; VRD SHALL hold MAR unchanged, assert read=1 and go to VCHK.
REQ-033 VCHK SHALL compare ms_in with the latched byte, set err=1 (sticky until the next start or rst) on mismatch, and then make the next-byte decision; throughput becomes 5 cycles per byte.
REQ-034 Without LOADER_VERIFY_EN, the VRD and VCHK states SHALL be absent, read and err SHALL be tied 0, and ms_in SHALL be unused.

Verification
REQ-035 Basic load: start, len=3, bytes 0xA1, 0xB2, 0xC3 each offered on arrival in WAIT -> MAR writes 0, 1, 2; store writes A1, B2, C3; done pulses once; core_hold falls the cycle after done.
REQ-036 len=0: 32 bytes 0x00..0x1F -> addresses 0..31 written in order, then done.
REQ-037 Backpressure: in_valid held at 0 for 10 cycles in WAIT -> no strobes occur, in_ready stays 1, and the session resumes when in_valid rises.
REQ-038 Reset mid-session: rst asserted in DATA of byte 2 -> next cycle all outputs are 0 and the FSM is in IDLE; a following start with len=1 writes address 0.
REQ-039 Verify (LOADER_VERIFY_EN): ms_in returns 0xFF for written byte 0x5A -> err=1 after VCHK and stays set through done; the next start clears it.
REQ-040 Idle start: start pulsed while in DATA -> ignored; the byte count and len are unchanged.
